// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the dual-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  // Encoding of the master that held the bus most recently
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts strobe-without-ack cycles and flags expiry at the limit.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic active,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Saturating stall counter; clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // Expiry only matters while a master holds the bus
  always_comb begin
    expire = active && (count == LIMIT);
  end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter merging instruction-fetch and data Wishbone masters onto one slave port.
module wb_dual_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    i_cyc_i,
  input  logic                    i_stb_i,
  input  logic [ADDR_WIDTH-1:0]   i_adr_i,
  output logic [DATA_WIDTH-1:0]   i_dat_o,
  output logic                    i_ack_o,
  output logic                    i_err_o,
  input  logic                    d_cyc_i,
  input  logic                    d_stb_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_sel_i,
  input  logic [ADDR_WIDTH-1:0]   d_adr_i,
  input  logic [DATA_WIDTH-1:0]   d_dat_i,
  output logic [DATA_WIDTH-1:0]   d_dat_o,
  output logic                    d_ack_o,
  output logic                    d_err_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_sel_o,
  output logic [ADDR_WIDTH-1:0]   m_adr_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  input  logic                    m_ack_i,
  output logic [1:0]              grant_o
);

  arb_state_t state;
  logic       last_grant;
  logic       i_req;
  logic       d_req;
  logic       gnt_i;
  logic       gnt_d;
  logic       gnt_cyc;
  logic       gnt_stb;
  logic       wd_enable;
  logic       wd_clear;
  logic       wd_active;
  logic       wd_expire;

  // Request and grant decode
  always_comb begin
    i_req   = i_cyc_i & i_stb_i;
    d_req   = d_cyc_i & d_stb_i;
    gnt_i   = (state == GNT_I);
    gnt_d   = (state == GNT_D);
    gnt_cyc = (gnt_i & i_cyc_i) | (gnt_d & d_cyc_i);
    gnt_stb = (gnt_i & i_stb_i) | (gnt_d & d_stb_i);
  end

  // Watchdog controls: count stalled strobes, restart on ack or when the grant ends
  always_comb begin
    wd_active = gnt_i | gnt_d;
    wd_enable = gnt_stb & ~m_ack_i;
    wd_clear  = ~wd_active | m_ack_i | ~gnt_cyc | wd_expire;
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_wd
      wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_watchdog (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .enable(wd_enable),
        .clear (wd_clear),
        .active(wd_active),
        .expire(wd_expire)
      );
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  // Arbitration FSM with bus locking, direct handoff and watchdog abort
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= LAST_D;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || (last_grant == LAST_D))) begin
            state <= GNT_I;
          end else if (d_req) begin
            state <= GNT_D;
          end
        end
        GNT_I: begin
          if (wd_expire) begin
            state      <= ABORT;
            last_grant <= LAST_I;
          end else if (!i_cyc_i) begin
            state      <= d_req ? GNT_D : IDLE;
            last_grant <= LAST_I;
          end
        end
        GNT_D: begin
          if (wd_expire) begin
            state      <= ABORT;
            last_grant <= LAST_D;
          end else if (!d_cyc_i) begin
            state      <= i_req ? GNT_I : IDLE;
            last_grant <= LAST_D;
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Slave-side mux; the instruction master is read-only with full byte lanes
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_sel_o = '0;
    m_adr_o = '0;
    m_dat_o = '0;
    if (gnt_i) begin
      m_cyc_o = i_cyc_i;
      m_stb_o = i_stb_i;
      m_sel_o = '1;
      m_adr_o = i_adr_i;
    end else if (gnt_d) begin
      m_cyc_o = d_cyc_i;
      m_stb_o = d_stb_i;
      m_we_o  = d_we_i;
      m_sel_o = d_sel_i;
      m_adr_o = d_adr_i;
      m_dat_o = d_dat_i;
    end
  end

  // Return path: ack/err/data reach only the master that holds an open cycle
  always_comb begin
    i_dat_o = gnt_i ? m_dat_i : '0;
    d_dat_o = gnt_d ? m_dat_i : '0;
    i_ack_o = gnt_i & i_cyc_i & m_ack_i;
    d_ack_o = gnt_d & d_cyc_i & m_ack_i;
    i_err_o = gnt_i & wd_expire;
    d_err_o = gnt_d & wd_expire;
    grant_o = ({2{gnt_i}} & GRANT_I) | ({2{gnt_d}} & GRANT_D);
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for the dual-master Wishbone arbiter.
module tb_wb_dual_master_arbiter;

  logic        clk;
  logic        rst;
  logic        i_cyc, i_stb;
  logic [31:0] i_adr, i_dat;
  logic        i_ack, i_err;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_adr, d_dato, d_dati;
  logic        d_ack, d_err;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dato, m_dati;
  logic        m_ack;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  wb_dual_master_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .i_cyc_i (i_cyc),
    .i_stb_i (i_stb),
    .i_adr_i (i_adr),
    .i_dat_o (i_dat),
    .i_ack_o (i_ack),
    .i_err_o (i_err),
    .d_cyc_i (d_cyc),
    .d_stb_i (d_stb),
    .d_we_i  (d_we),
    .d_sel_i (d_sel),
    .d_adr_i (d_adr),
    .d_dat_i (d_dati),
    .d_dat_o (d_dato),
    .d_ack_o (d_ack),
    .d_err_o (d_err),
    .m_cyc_o (m_cyc),
    .m_stb_o (m_stb),
    .m_we_o  (m_we),
    .m_sel_o (m_sel),
    .m_adr_o (m_adr),
    .m_dat_o (m_dato),
    .m_dat_i (m_dati),
    .m_ack_i (m_ack),
    .grant_o (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    rst = 1'b1;
    i_cyc = 0; i_stb = 0; i_adr = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '0; d_adr = '0; d_dati = '0;
    m_dati = 32'hCAFE_F00D; m_ack = 0;

    // Reset state: everything low even with slave data present
    #2;
    chk("rst_m_cyc", 32'(m_cyc), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_i_dat", i_dat, 32'd0);
    chk("rst_d_dat", d_dato, 32'd0);
    step();
    rst = 1'b0;

    // 1. Instruction master alone
    i_cyc = 1; i_stb = 1; i_adr = 32'h100;
    #1;
    chk("t1_latency_m_cyc", 32'(m_cyc), 32'd0);
    step();
    #1;
    chk("t1_m_cyc", 32'(m_cyc), 32'd1);
    chk("t1_m_adr", m_adr, 32'h100);
    chk("t1_m_we", 32'(m_we), 32'd0);
    chk("t1_m_sel", 32'(m_sel), 32'hF);
    chk("t1_grant", 32'(grant), 32'h1);
    step();
    m_ack = 1; m_dati = 32'hDEAD_BEEF;
    #1;
    chk("t1_i_ack", 32'(i_ack), 32'd1);
    chk("t1_i_dat", i_dat, 32'hDEAD_BEEF);
    chk("t1_d_ack", 32'(d_ack), 32'd0);
    step();
    m_ack = 0; i_cyc = 0; i_stb = 0;
    #1;
    chk("t1_i_ack_off", 32'(i_ack), 32'd0);
    chk("t1_m_cyc_off", 32'(m_cyc), 32'd0);
    step();
    chk("t1_idle", 32'(grant), 32'd0);

    // 2. Simultaneous requests right after reset, then direct handoff
    rst = 1; #1; rst = 0;
    i_cyc = 1; i_stb = 1; i_adr = 32'h300;
    d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'h3; d_adr = 32'h2000; d_dati = 32'h1234_5678;
    step();
    chk("t2_first_grant", 32'(grant), 32'h1);
    chk("t2_i_we", 32'(m_we), 32'd0);
    chk("t2_i_adr", m_adr, 32'h300);
    m_ack = 1;
    #1;
    chk("t2_i_ack", 32'(i_ack), 32'd1);
    chk("t2_d_ack_held", 32'(d_ack), 32'd0);
    step();
    m_ack = 0; i_cyc = 0; i_stb = 0;
    step();
    chk("t2_handoff_grant", 32'(grant), 32'h2);
    chk("t2_m_cyc", 32'(m_cyc), 32'd1);
    chk("t2_m_we", 32'(m_we), 32'd1);
    chk("t2_m_sel", 32'(m_sel), 32'h3);
    chk("t2_m_dat", m_dato, 32'h1234_5678);
    chk("t2_m_adr", m_adr, 32'h2000);
    m_ack = 1;
    #1;
    chk("t2_d_ack", 32'(d_ack), 32'd1);
    chk("t2_i_ack_held", 32'(i_ack), 32'd0);
    step();
    m_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    step();
    chk("t2_idle", 32'(grant), 32'd0);

    // 3. Continuous requests from both: grants alternate I, D, I, D ...
    i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
    step();
    exp_g = 2'b01;
    for (int k = 0; k < 8; k++) begin
      m_ack = 1;
      #1;
      chk("t3_grant", 32'(grant), 32'(exp_g));
      chk("t3_not_both", 32'(grant == 2'b11), 32'd0);
      chk("t3_ack", 32'(exp_g[0] ? i_ack : d_ack), 32'd1);
      step();
      m_ack = 0;
      if (exp_g[0]) begin
        i_cyc = 0; i_stb = 0;
      end else begin
        d_cyc = 0; d_stb = 0;
      end
      step();
      i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
      exp_g = ~exp_g;
    end
    i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
    step();
    chk("t3_idle", 32'(grant), 32'd0);

    // 4. Watchdog: stalled data strobe aborts, pending instr granted afterwards
    d_cyc = 1; d_stb = 1;
    step();
    i_cyc = 1; i_stb = 1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("t4_no_err_early", 32'(d_err), 32'd0);
      chk("t4_grant_d", 32'(grant), 32'h2);
      step();
    end
    #1;
    chk("t4_d_err", 32'(d_err), 32'd1);
    chk("t4_i_err", 32'(i_err), 32'd0);
    chk("t4_m_cyc_before_abort", 32'(m_cyc), 32'd1);
    step();
    d_cyc = 0; d_stb = 0;
    #1;
    chk("t4_abort_m_cyc", 32'(m_cyc), 32'd0);
    chk("t4_abort_err_gone", 32'(d_err), 32'd0);
    chk("t4_abort_grant", 32'(grant), 32'd0);
    step();
    chk("t4_idle_grant", 32'(grant), 32'd0);
    step();
    chk("t4_instr_next", 32'(grant), 32'h1);
    i_cyc = 0; i_stb = 0;
    step();
    step();

    // 5. Data master abandons before ack; late slave ack is dropped
    d_cyc = 1; d_stb = 1;
    step();
    chk("t5_grant_d", 32'(grant), 32'h2);
    d_cyc = 0; d_stb = 0;
    #1;
    chk("t5_m_cyc_same_cycle", 32'(m_cyc), 32'd0);
    chk("t5_m_stb_same_cycle", 32'(m_stb), 32'd0);
    step();
    m_ack = 1;
    #1;
    chk("t5_late_d_ack", 32'(d_ack), 32'd0);
    chk("t5_late_i_ack", 32'(i_ack), 32'd0);
    step();
    m_ack = 0;

    // 6. Asynchronous reset in the middle of a data transfer
    d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'hF;
    step();
    chk("t6_grant_d", 32'(grant), 32'h2);
    m_dati = 32'h5555_AAAA;
    #1;
    chk("t6_d_dat", d_dato, 32'h5555_AAAA);
    rst = 1;
    #1;
    chk("t6_rst_m_cyc", 32'(m_cyc), 32'd0);
    chk("t6_rst_m_we", 32'(m_we), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_d_dat", d_dato, 32'd0);
    step();
    rst = 0;
    i_cyc = 1; i_stb = 1;
    step();
    chk("t6_instr_first", 32'(grant), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
